msx_wait_gen: RTL
=================

Name: msx_wait_gen

Overview:
Parametrised CPU wait-state generator, the successor of the fixed M1-only wait counter in the MSX top level. Sits between the CPU bus and the TV80a WAIT_n input. Inserts configurable T-state waits per bus-cycle type and per primary slot, and merges N maskable external device wait requests. Adds timeout protection, an error flag and a saturating wait-statistics counter.

Parameters:
CNT_W, 3, width of every wait-count config field (max waits = 2^CNT_W-1)
N_EXT, 4, number of external wait request sources
TIMEOUT, 255, max CPU T-states an external wait may hold; 0 disables timeout
TO_W, 8, width of timeout counter (TIMEOUT must fit)
STAT_W, 16, width of wait statistics counter

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
ce  in  1  CPU T-state enable, one clk pulse per CPU clock (negative phase)
m1  in  1  CPU M1, active high
mreq  in  1  memory request, active high
iorq  in  1  I/O request, active high
rfsh  in  1  refresh, active high
page  in  2  cpu addr[15:14]
slot_config  in  8  primary slot register, 2 bits per page
m1_wait  in  CNT_W  extra waits on opcode fetch
mem_wait  in  4*CNT_W  memory waits per primary slot, slot n at [n*CNT_W +: CNT_W]
io_wait  in  CNT_W  waits on I/O cycles
ext_wait  in  N_EXT  external wait requests, active high
ext_wait_mask  in  N_EXT  1 = source enabled
clear_err  in  1  clears timeout_err, wait_total
wait_n  out  1  to CPU WAIT_n, active low
timeout_err  out  1  sticky: an external wait was forcibly released
wait_total  out  STAT_W  saturating count of inserted wait T-states

Behaviour:
- Reset (async, reset_n=0): state IDLE, counters 0, wait_n=1, timeout_err=0, wait_total=0. Reset mid-wait releases wait_n immediately.
- All state changes occur only on clk edges with ce=1, except reset and clear_err (any clk edge).
- req = (mreq|iorq) & ~rfsh. start = req & ~req_q, req_q registered on ce. Refresh cycles never start.
- slot = slot_config[2*page +: 2]. Load value at start:
  m1&mreq: max(m1_wait, mem_wait[slot]);
  mreq&~m1: mem_wait[slot];
  iorq&~m1: io_wait;
  iorq&m1 (interrupt ack): 0.
  Config latched at start; later config changes do not affect the current cycle. ext_wait and mask sampled live.
- ext_act = |(ext_wait & ext_wait_mask).
- FSM (ce-qualified):
  IDLE: start & load!=0 -> COUNT, cnt=load. start & load==0 & ext_act -> EXT, to_cnt=0. start otherwise -> DONE.
  COUNT: cnt decrements; at cnt==1 -> EXT (to_cnt=0) if ext_act else DONE.
  EXT: ~ext_act -> DONE. Else to_cnt++; if TIMEOUT!=0 and to_cnt==TIMEOUT-1 -> DONE, timeout_err=1.
  DONE: ~req -> IDLE.
  Any state: ~req (cycle aborted) -> IDLE.
- wait_n = ~(state==COUNT | state==EXT), decoded from registered state. First wait T-state is the ce after start (T2 sampling). Exactly load T-states of wait_n=0 for internal waits.
- wait_total increments on each ce with wait_n=0; saturates at all ones; no wrap.
- clear_err and a simultaneous timeout: set wins (timeout_err=1, wait_total cleared).
- External assertion arriving after DONE is ignored until next cycle.

Test Plan:
- M1 fetch, m1_wait=2, mem_wait[slot0]=1, page0 slot0 -> wait_n low exactly 2 ce, wait_total=2.
- Memory read page2, slot_config=8'h20 (page2 slot2), mem_wait[2]=3 -> 3 wait ce; same with slot_config=0 and mem_wait[0]=0 -> no wait.
- I/O write io_wait=0, ext_wait[1]=1 mask=4'b0010 held 5 ce then dropped -> wait_n low 5 ce, timeout_err=0; mask=0 -> no wait.
- TIMEOUT=8, ext_wait stuck high -> wait_n low 8 ce then released, timeout_err=1; clear_err -> timeout_err=0, wait_total=0.
- reset_n pulsed low during COUNT with cnt=5 -> wait_n=1 same cycle, all outputs reset; refresh cycle (rfsh=1, mreq=1) and INTA (m1&iorq) -> no wait.
- Preload wait_total near max (STAT_W=4 build): 20 waits -> wait_total holds 15.

Source files
------------

// File: rtl/msx_wait_gen_if.sv
// CPU bus view seen by the wait-state generator.
// The CPU side drives cycle strobes; the generator returns WAIT_n.
interface msx_wait_gen_if;
  logic       ce;
  logic       m1;
  logic       mreq;
  logic       iorq;
  logic       rfsh;
  logic [1:0] page;
  logic       wait_n;

  modport master (
    output ce, m1, mreq, iorq, rfsh, page,
    input  wait_n
  );

  modport slave (
    input  ce, m1, mreq, iorq, rfsh, page,
    output wait_n
  );
endinterface

// File: rtl/msx_wait_gen.sv
// MSX CPU wait-state generator: per-cycle-type and per-slot waits,
// maskable external wait merge, timeout and wait statistics.
module msx_wait_gen #(
  parameter int CNT_W   = 3,
  parameter int N_EXT   = 4,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8,
  parameter int STAT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  msx_wait_gen_if.slave     bus,
  input  logic [7:0]        slot_config,
  input  logic [CNT_W-1:0]  m1_wait,
  input  logic [4*CNT_W-1:0] mem_wait,
  input  logic [CNT_W-1:0]  io_wait,
  input  logic [N_EXT-1:0]  ext_wait,
  input  logic [N_EXT-1:0]  ext_wait_mask,
  input  logic              clear_err,
  output logic              timeout_err,
  output logic [STAT_W-1:0] wait_total
);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    EXT,
    DONE
  } state_t;

  localparam int TO_LIM = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [TO_W-1:0] TO_MAX = TO_LIM[TO_W-1:0];

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TO_W-1:0]     to_q, to_d;
  logic                req_q, req_d;
  logic                err_q, err_d;
  logic [STAT_W-1:0]   tot_q, tot_d;
  logic                wait_q, wait_d;

  logic                req;
  logic                start;
  logic                ext_act;
  logic                set_err;
  logic [1:0]          slot;
  logic [CNT_W-1:0]    mem_sel;
  logic [CNT_W-1:0]    load;

  always_comb begin
    req     = (bus.mreq | bus.iorq) & ~bus.rfsh;
    start   = req & ~req_q;
    ext_act = |(ext_wait & ext_wait_mask);
    slot    = slot_config[{bus.page, 1'b0} +: 2];
    mem_sel = mem_wait[slot*CNT_W +: CNT_W];
    if (bus.mreq && bus.m1) begin
      load = (m1_wait > mem_sel) ? m1_wait : mem_sel;
    end else if (bus.mreq) begin
      load = mem_sel;
    end else if (bus.iorq && !bus.m1) begin
      load = io_wait;
    end else begin
      load = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    req_d   = req_q;
    set_err = 1'b0;
    if (bus.ce) begin
      req_d = req;
      if (!req) begin
        state_d = IDLE;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start) begin
              if (load != '0) begin
                state_d = COUNT;
                cnt_d   = load;
              end else if (ext_act) begin
                state_d = EXT;
                to_d    = '0;
              end else begin
                state_d = DONE;
              end
            end
          end
          COUNT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              to_d    = '0;
              state_d = ext_act ? EXT : DONE;
            end
          end
          EXT: begin
            if (!ext_act) begin
              state_d = DONE;
            end else begin
              to_d = to_q + TO_W'(1);
              if (TIMEOUT != 0 && to_q == TO_MAX) begin
                state_d = DONE;
                set_err = 1'b1;
              end
            end
          end
          DONE: begin
            state_d = DONE;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // WAIT_n is registered straight from the next-state decode.
  always_comb begin
    wait_d = ~(state_d == COUNT || state_d == EXT);
    err_d  = err_q;
    if (set_err) begin
      err_d = 1'b1;
    end else if (clear_err) begin
      err_d = 1'b0;
    end
    tot_d = tot_q;
    if (clear_err) begin
      tot_d = '0;
    end else if (bus.ce && !wait_q && !(&tot_q)) begin
      tot_d = tot_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      to_q    <= '0;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
      tot_q   <= '0;
      wait_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      req_q   <= req_d;
      err_q   <= err_d;
      tot_q   <= tot_d;
      wait_q  <= wait_d;
    end
  end

  assign bus.wait_n  = wait_q;
  assign timeout_err = err_q;
  assign wait_total  = tot_q;

endmodule
